stream_pack: RTL and testbench
==============================

Name: stream_pack

Overview:
- Single-clock upstream stage for the two-phase CDC.
- Gathers Ratio narrow valid/ready words into one wide beat, filling the LSB lane first.
- The CDC then carries one wide transfer per handshake round-trip instead of one narrow word, which amortises its multi-cycle handshake latency.
- The output beat is registered, so no combinational path runs from ready_i to the CDC source data.

Parameters:
- InWidth, 8: width of one input word in bits (>=1).
- Ratio, 4: number of input words per output beat (>=2).
- OutWidth, InWidth*Ratio: width of the output beat. Derived; not overridable.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- clr_i  input  1  synchronous clear; drops all buffered state.
- flush_i  input  1  close the current partial beat.
- data_i  input  InWidth  input word.
- last_i  input  1  this word ends a packet.
- valid_i  input  1  input valid.
- ready_o  output  1  input ready.
- data_o  output  OutWidth  packed beat; lane k = bits [k*InWidth +: InWidth].
- strb_o  output  Ratio  per-lane occupancy.
- last_o  output  1  beat ends a packet.
- valid_o  output  1  output valid.
- ready_i  input  1  output ready.

Behaviour:
- State:
  - beat register: data_q, strb_q, last_q, valid_q;
  - lane counter cnt_q, width $clog2(Ratio), range 0..Ratio-1.
- Reset (rst_ni=0 at a clk_i edge) and clr_i=1 both force all registers to 0. Consequently valid_o=0, strb_o=0, data_o=0, last_o=0, and ready_o=1 the cycle after. clr_i takes priority over every other input.
- Definitions:
  - out_hs = valid_o && ready_i;
  - in_hs = valid_i && ready_o.
- ready_o = !valid_q || ready_i. The block accepts input while a completed beat is being drained.
- States:
  - FILL: valid_q=0, cnt_q = number of lanes occupied.
  - HOLD: valid_q=1, beat complete, waiting for ready_i.
- On in_hs:
  - data_i is written to lane L, where L = 0 if out_hs else cnt_q;
  - strb bit L is set;
  - on out_hs, all other lanes and strb bits clear in the same cycle.
- Beat close: the beat closes (valid_q<=1, cnt_q<=0) when in_hs occurs and (L==Ratio-1 or last_i). last_q<=last_i.
- Otherwise on in_hs: cnt_q <= L+1.
- Flush:
  - flush_i=1 with cnt_q>0 (or in_hs this cycle) and valid_q=0 closes the beat with last_q=0, or with last_i if a word is accepted the same cycle.
  - flush_i on an empty buffer, or while in HOLD, is ignored.
- On out_hs without a closing in_hs: valid_q<=0, strb_q<=0, data_q<=0, last_q<=0.
- Unused lanes are always 0 in data_o; strb_o is always a contiguous run of ones from bit 0.
- Latency: valid_o rises the cycle after the closing word is accepted.
- Throughput: one input word per cycle sustained when ready_i=1.
- While valid_o=1, data_o/strb_o/last_o are stable until out_hs. This is AXI-stream style: valid never drops without a handshake, except on clr_i or reset.
- Simultaneous out_hs and in_hs, when the input completes a one-word beat (last_i=1): the new beat is valid again next cycle with strb=...0001.

Decomposition:
- No shared package needed. Lane index width and OutWidth are localparams.
- No sub-module: counter and beat register sit inline.
- Downstream instance: the CDC with T = struct of data/strb/last, which is a typedef declared by the integrating top.

Test Plan:
All cases use InWidth=8, Ratio=4.
1. Reset/idle: hold rst_ni=0 for 2 cycles, release -> valid_o=0, ready_o=1, strb_o=0, data_o=0.
2. Full beat: words 0x11,0x22,0x33,0x44 back-to-back, ready_i=1 -> one cycle later data_o=0x44332211, strb_o=4'b1111, last_o=0; 8 words produce 2 beats on consecutive 4-cycle boundaries with no bubble.
3. Short packet: 0xA1,0xA2 with last_i on 0xA2 -> data_o=0x0000A2A1, strb_o=4'b0011, last_o=1.
4. Backpressure: complete a beat, ready_i=0 for 5 cycles -> ready_o=0, outputs stable. Then ready_i=1 with 0x55 valid -> 0x55 accepted that same cycle into lane 0 of the new beat.
5. Flush: 0x01,0x02,0x03 then flush_i for 1 cycle -> strb_o=4'b0111, last_o=0, data_o=0x00030201. Flush on empty -> no beat.
6. clr_i mid-fill after 2 words, then 4 new words -> first output beat contains only the 4 new words.

Source files
------------

// File: rtl/stream_pack.sv
// stream_pack: gathers Ratio narrow valid/ready words into one registered wide
// beat (lane 0 filled first) so the downstream CDC moves one wide transfer per
// handshake round-trip. Outputs come straight from registers.
module stream_pack #(
  parameter int unsigned InWidth = 8,
  parameter int unsigned Ratio   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       flush_i,
  input  logic [InWidth-1:0]         data_i,
  input  logic                       last_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [InWidth*Ratio-1:0]   data_o,
  output logic [Ratio-1:0]           strb_o,
  output logic                       last_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int unsigned OutWidth = InWidth * Ratio;
  localparam int unsigned LaneW    = $clog2(Ratio);
  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

  logic [OutWidth-1:0] data_q, data_d;
  logic [Ratio-1:0]    strb_q, strb_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic [LaneW-1:0]    cnt_q, cnt_d;

  logic             out_hs;
  logic             in_hs;
  logic [LaneW-1:0] lane;
  logic             flush_close;
  logic             word_close;

  // A held beat may be drained and refilled in the same cycle.
  assign ready_o = !valid_q || ready_i;
  assign out_hs  = valid_q && ready_i;
  assign in_hs   = valid_i && ready_o;

  // Draining frees the whole beat, so a word arriving alongside goes to lane 0.
  assign lane = out_hs ? '0 : cnt_q;

  // Flush only acts on a partial beat that is still filling and not empty.
  assign flush_close = flush_i && !valid_q && ((cnt_q != '0) || in_hs);
  assign word_close  = in_hs && ((lane == LastLane) || last_i);

  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

  // Next-state for the beat register and lane counter.
  always_comb begin
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (out_hs) begin
      data_d  = '0;
      strb_d  = '0;
      last_d  = 1'b0;
      valid_d = 1'b0;
    end

    if (in_hs) begin
      data_d[lane*InWidth +: InWidth] = data_i;
      strb_d[lane]                    = 1'b1;
      cnt_d                           = LaneW'(lane + 1'b1);
    end

    if (word_close || flush_close) begin
      valid_d = 1'b1;
      cnt_d   = '0;
      last_d  = in_hs ? last_i : 1'b0;
    end
  end

  // Beat register and counter; clear has priority over all traffic.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_pack.sv
// Bench for stream_pack (InWidth=8, Ratio=4): directed scenarios plus random
// traffic, compared each cycle against a word-queue reference model.
module tb_stream_pack;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clr_i, flush_i, last_i, valid_i, ready_i;
  logic [7:0]  data_i;
  logic        ready_o, last_o, valid_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;

  int checks = 0;
  int errors = 0;

  // model: words of the beat being filled, plus the completed beat on offer
  logic [7:0]  m_cur[$];
  bit          m_hv;
  logic [31:0] m_hdata;
  logic [3:0]  m_hstrb;
  bit          m_hlast;

  stream_pack #(.InWidth(8), .Ratio(4)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .flush_i (flush_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .strb_o  (strb_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_words();
    logic [31:0] acc = '0;
    for (int i = 0; i < m_cur.size(); i++) acc |= 32'(m_cur[i]) << (8 * i);
    return acc;
  endfunction

  function automatic logic [3:0] fill_mask();
    return 4'((1 << m_cur.size()) - 1);
  endfunction

  task automatic model_clear();
    m_cur.delete();
    m_hv = 0; m_hdata = '0; m_hstrb = '0; m_hlast = 0;
  endtask

  // drive one cycle of inputs, compare DUT outputs to the model, then advance the model
  task automatic step(input bit v, input logic [7:0] d, input bit l,
                      input bit f, input bit r, input bit c);
    bit ohs, ihs, was_hold, closing;
    @(negedge clk_i);
    valid_i = v; data_i = d; last_i = l; flush_i = f; ready_i = r; clr_i = c;
    #1;
    check("valid_o", 32'(valid_o), 32'(m_hv));
    check("data_o",  data_o, m_hv ? m_hdata : pack_words());
    check("strb_o",  32'(strb_o), 32'(m_hv ? m_hstrb : fill_mask()));
    check("last_o",  32'(last_o), 32'(m_hv ? m_hlast : 1'b0));
    check("ready_o", 32'(ready_o), 32'(!m_hv || r));
    if (c) begin
      model_clear();
    end else begin
      was_hold = m_hv;
      ohs = m_hv && r;
      ihs = v && (!m_hv || r);
      if (ohs) begin
        m_hv = 0; m_hdata = '0; m_hstrb = '0; m_hlast = 0;
      end
      if (ihs) m_cur.push_back(d);
      closing = (ihs && (m_cur.size() == 4 || l)) || (f && !was_hold && m_cur.size() > 0);
      if (closing) begin
        m_hv    = 1;
        m_hdata = pack_words();
        m_hstrb = fill_mask();
        m_hlast = ihs ? l : 1'b0;
        m_cur.delete();
      end
    end
  endtask

  task automatic idle(input bit r);
    step(0, 8'h00, 0, 0, r, 0);
  endtask

  // sample right after the edge that follows the most recent step
  task automatic after_edge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 0; flush_i = 0; last_i = 0; valid_i = 0; ready_i = 0; data_i = '0;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_strb",  32'(strb_o), 32'd0);
    check("rst_data",  data_o, 32'd0);

    // full beat, then two more back-to-back
    step(1, 8'h11, 0, 0, 1, 0);
    step(1, 8'h22, 0, 0, 1, 0);
    step(1, 8'h33, 0, 0, 1, 0);
    step(1, 8'h44, 0, 0, 1, 0);
    after_edge();
    check("full_data",  data_o, 32'h44332211);
    check("full_strb",  32'(strb_o), 32'hF);
    check("full_last",  32'(last_o), 32'd0);
    check("full_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0, 0, 1, 0);
    idle(1);

    // short packet
    step(1, 8'hA1, 0, 0, 1, 0);
    step(1, 8'hA2, 1, 0, 1, 0);
    after_edge();
    check("short_data", data_o, 32'h0000A2A1);
    check("short_strb", 32'(strb_o), 32'h3);
    check("short_last", 32'(last_o), 32'd1);
    idle(1);

    // backpressure, then drain with a concurrent word
    for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'hEE, 0, 0, 0, 0);
    step(1, 8'h55, 0, 0, 1, 0);
    after_edge();
    check("bp_valid", 32'(valid_o), 32'd0);
    check("bp_strb",  32'(strb_o), 32'h1);
    check("bp_data",  data_o, 32'h00000055);
    step(1, 8'h56, 1, 0, 1, 0);
    idle(1);

    // flush a partial beat, then flush on empty
    step(1, 8'h01, 0, 0, 1, 0);
    step(1, 8'h02, 0, 0, 1, 0);
    step(1, 8'h03, 0, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0, 0);
    after_edge();
    check("flush_strb", 32'(strb_o), 32'h7);
    check("flush_last", 32'(last_o), 32'd0);
    check("flush_data", data_o, 32'h00030201);
    idle(1);
    step(0, 8'h00, 0, 1, 1, 0);
    after_edge();
    check("flush_empty_valid", 32'(valid_o), 32'd0);

    // clear mid-fill
    step(1, 8'hC1, 0, 0, 1, 0);
    step(1, 8'hC2, 0, 0, 1, 0);
    step(1, 8'hC3, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hD0 + i), 0, 0, 1, 0);
    after_edge();
    check("clr_data", data_o, 32'hD3D2D1D0);
    check("clr_strb", 32'(strb_o), 32'hF);
    idle(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(bit'($urandom_range(0, 3) != 0), 8'($urandom),
           bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 99) == 0));
    end
    idle(1);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
